// File: rtl/gci_node_irq_req.sv
// Purpose: GCI node IRQ source; edge-detects local events, queues cause codes, requests the bus arbiter.
// Latency: event edge -> pending +1 cycle -> FIFO push +1 cycle -> oIRQ in the same cycle the entry becomes visible.
// Backpressure: full FIFO parks causes in b_pending; iIRQ_BUSY/iIRQ_ENABLE hold off new requests, never a raised one.
//
// Ports:
//   iCLOCK, iRESET         clock, asynchronous active-high reset
//   iEVENT, iEVENT_MASK    event levels (rising edge = event) and per-source enable
//   iIRQ_ENABLE, iIRQ_BUSY global request enable, arbiter busy
//   oIRQ, iIRQ_ACK         request to / grant from the arbiter
//   oCAUSE_VALID, oCAUSE   head of cause FIFO
//   iCAUSE_POP             software pops head cause
//   oFIFO_COUNT            entries held
//   oCOALESCE, iCOALESCE_CLR sticky "event hit an already-pending source" flag and its clear

// Small generic FIFO: caller guarantees push only when not full, pop only when not empty.
// Latency: pushed entry visible at oHead/oCount the cycle after the push.
// Backpressure: none internally; oCount tells the caller when it is full or empty.
module gci_node_irq_req_fifo #(
    parameter int P_W       = 3,
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iPush,
    input  logic [P_W-1:0]       iPushData,
    input  logic                 iPop,
    output logic [P_W-1:0]       oHead,
    output logic [P_DEPTH_N:0]   oCount
);
    logic [P_W-1:0]       mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] wrPtr;
    logic [P_DEPTH_N-1:0] rdPtr;
    logic [P_DEPTH_N:0]   count;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (iPush) begin
                mem[wrPtr] <= iPushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (iPop) rdPtr <= rdPtr + 1'b1;
            case ({iPush, iPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign oHead  = mem[rdPtr];
    assign oCount = count;
endmodule

module gci_node_irq_req #(
    parameter int P_SRC_N        = 8,
    parameter int P_SRC_N_W      = 3,
    parameter int P_FIFO_DEPTH   = 4,
    parameter int P_FIFO_DEPTH_N = 2
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET,
    input  logic [P_SRC_N-1:0]        iEVENT,
    input  logic [P_SRC_N-1:0]        iEVENT_MASK,
    input  logic                      iIRQ_ENABLE,
    input  logic                      iIRQ_BUSY,
    output logic                      oIRQ,
    input  logic                      iIRQ_ACK,
    output logic                      oCAUSE_VALID,
    output logic [P_SRC_N_W-1:0]      oCAUSE,
    input  logic                      iCAUSE_POP,
    output logic [P_FIFO_DEPTH_N:0]   oFIFO_COUNT,
    output logic                      oCOALESCE,
    input  logic                      iCOALESCE_CLR
);
    localparam int CNT_W = P_FIFO_DEPTH_N + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

    state_t               state;
    logic [P_SRC_N-1:0]   b_event_prev;
    logic [P_SRC_N-1:0]   b_pending;
    logic [CNT_W-1:0]     b_undeliv;
    logic [CNT_W-1:0]     undelivNext;
    logic [CNT_W-1:0]     fifoCount;
    logic [P_SRC_N-1:0]   edgeDet;
    logic [P_SRC_N-1:0]   clrMask;
    logic [P_SRC_N_W-1:0] pushIdx;
    logic                 pushEn;
    logic                 popEn;
    logic                 ackDec;
    logic                 popDiscard;
    logic                 coalesceSet;

    assign edgeDet = iEVENT & ~b_event_prev & iEVENT_MASK;

    // Lowest-index pending source wins: scan downward so the last hit is the lowest.
    always_comb begin
        pushIdx = '0;
        for (int i = P_SRC_N - 1; i >= 0; i--) begin
            if (b_pending[i]) pushIdx = P_SRC_N_W'(i);
        end
    end

    // Full test uses the registered count, so a same-cycle pop does not open a slot.
    assign pushEn  = (|b_pending) && (fifoCount != CNT_W'(P_FIFO_DEPTH));
    assign clrMask = pushEn ? (P_SRC_N'(1) << pushIdx) : '0;
    assign popEn   = iCAUSE_POP && (fifoCount != '0);

    // A bit being drained this cycle is not "already pending" for a new edge.
    assign coalesceSet = |(edgeDet & b_pending & ~clrMask);

    // Grants are counted only while something is undelivered; a late grant for a
    // discarded head saturates at zero. A discard plus a grant in one cycle
    // refers to the same cause, hence a single decrement.
    assign ackDec     = (state == ST_REQ) && iIRQ_ACK && (b_undeliv != '0);
    assign popDiscard = popEn && (b_undeliv == fifoCount);

    always_comb begin
        case ({pushEn, ackDec || popDiscard})
            2'b10:   undelivNext = b_undeliv + CNT_W'(1);
            2'b01:   undelivNext = b_undeliv - CNT_W'(1);
            default: undelivNext = b_undeliv;
        endcase
    end

    gci_node_irq_req_fifo #(
        .P_W       (P_SRC_N_W),
        .P_DEPTH   (P_FIFO_DEPTH),
        .P_DEPTH_N (P_FIFO_DEPTH_N)
    ) u_fifo (
        .iCLOCK    (iCLOCK),
        .iRESET    (iRESET),
        .iPush     (pushEn),
        .iPushData (pushIdx),
        .iPop      (popEn),
        .oHead     (oCAUSE),
        .oCount    (fifoCount)
    );

    assign oFIFO_COUNT  = fifoCount;
    assign oCAUSE_VALID = (fifoCount != '0);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            b_event_prev <= '0;
            b_pending    <= '0;
            b_undeliv    <= '0;
            oCOALESCE    <= 1'b0;
        end else begin
            b_event_prev <= iEVENT;
            b_pending    <= (b_pending & ~clrMask) | edgeDet;
            b_undeliv    <= undelivNext;
            if (coalesceSet)        oCOALESCE <= 1'b1;
            else if (iCOALESCE_CLR) oCOALESCE <= 1'b0;
        end
    end

    // Request FSM. Entry into REQ looks at the post-push count so a cause pushed
    // this cycle raises oIRQ together with oCAUSE_VALID. HOLD masks the
    // arbiter's combinational ACK for one cycle after a grant.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= ST_IDLE;
            oIRQ  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((undelivNext != '0) && iIRQ_ENABLE && !iIRQ_BUSY) begin
                        state <= ST_REQ;
                        oIRQ  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (iIRQ_ACK) begin
                        state <= ST_HOLD;
                        oIRQ  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state <= ST_IDLE;
                    oIRQ  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    oIRQ  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gci_node_irq_req.sv
module tb_gci_node_irq_req;
    logic       iCLOCK = 1'b0;
    logic       iRESET;
    logic [7:0] iEVENT;
    logic [7:0] iEVENT_MASK;
    logic       iIRQ_ENABLE;
    logic       iIRQ_BUSY;
    logic       iIRQ_ACK;
    logic       iCAUSE_POP;
    logic       iCOALESCE_CLR;
    logic       oIRQ;
    logic       oCAUSE_VALID;
    logic [2:0] oCAUSE;
    logic [2:0] oFIFO_COUNT;
    logic       oCOALESCE;

    int tests = 0;
    int fails = 0;

    gci_node_irq_req #(
        .P_SRC_N(8), .P_SRC_N_W(3), .P_FIFO_DEPTH(4), .P_FIFO_DEPTH_N(2)
    ) dut (
        .iCLOCK        (iCLOCK),
        .iRESET        (iRESET),
        .iEVENT        (iEVENT),
        .iEVENT_MASK   (iEVENT_MASK),
        .iIRQ_ENABLE   (iIRQ_ENABLE),
        .iIRQ_BUSY     (iIRQ_BUSY),
        .oIRQ          (oIRQ),
        .iIRQ_ACK      (iIRQ_ACK),
        .oCAUSE_VALID  (oCAUSE_VALID),
        .oCAUSE        (oCAUSE),
        .iCAUSE_POP    (iCAUSE_POP),
        .oFIFO_COUNT   (oFIFO_COUNT),
        .oCOALESCE     (oCOALESCE),
        .iCOALESCE_CLR (iCOALESCE_CLR)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Reference model: queue of causes, each tagged with whether the arbiter has granted it.
    typedef struct { int cause; bit granted; } ent_t;
    ent_t     mQ[$];
    bit [7:0] mPrev;
    bit [7:0] mPend;
    int       mPhase;   // 0 idle, 1 requesting, 2 post-grant gap
    bit       mCoal;

    task automatic model_reset();
        mQ.delete();
        mPrev = '0; mPend = '0; mPhase = 0; mCoal = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int cnt, pidx, ungranted;
        bit [7:0] ev;
        bit coal;
        if (iRESET) begin
            model_reset();
            return;
        end
        cnt  = mQ.size();
        ev   = iEVENT & ~mPrev & iEVENT_MASK;
        pidx = -1;
        if (cnt < 4) begin
            for (int i = 7; i >= 0; i--) if (mPend[i]) pidx = i;
        end
        coal = 0;
        for (int i = 0; i < 8; i++) if (ev[i] && mPend[i] && i != pidx) coal = 1;
        if (mPhase == 1 && iIRQ_ACK) begin
            for (int k = 0; k < mQ.size(); k++) begin
                if (!mQ[k].granted) begin
                    mQ[k].granted = 1;
                    break;
                end
            end
        end
        if (iCAUSE_POP && cnt > 0) void'(mQ.pop_front());
        if (pidx >= 0) begin
            mQ.push_back('{cause: pidx, granted: 1'b0});
            mPend[pidx] = 1'b0;
        end
        mPend = mPend | ev;
        if (coal) mCoal = 1;
        else if (iCOALESCE_CLR) mCoal = 0;
        ungranted = 0;
        foreach (mQ[k]) if (!mQ[k].granted) ungranted++;
        case (mPhase)
            0: if (ungranted > 0 && iIRQ_ENABLE && !iIRQ_BUSY) mPhase = 1;
            1: if (iIRQ_ACK) mPhase = 2;
            default: mPhase = 0;
        endcase
        mPrev = iEVENT;
    endtask

    task automatic tick();
        model_step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_reset();
        iRESET = 1; iEVENT = 0; iEVENT_MASK = 8'hFF; iIRQ_ENABLE = 1; iIRQ_BUSY = 0;
        iIRQ_ACK = 0; iCAUSE_POP = 0; iCOALESCE_CLR = 0;
        model_reset();
        #3;
        tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", oIRQ); end
        tests++; if (oCAUSE_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", oCAUSE_VALID); end
        tick(); tick();
        iRESET = 0;
        tick();
        tests++; if (oFIFO_COUNT !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", oFIFO_COUNT); end
        tests++; if (oCAUSE !== 3'd0) begin fails++; $display("FAIL reset_cause got %0d want 0", oCAUSE); end
        tests++; if (oCOALESCE !== 1'b0 || oIRQ !== 1'b0) begin fails++; $display("FAIL reset_coal_irq got %b%b want 00", oCOALESCE, oIRQ); end
    endtask

    task automatic test_single();
        iEVENT = 8'h20; tick(); iEVENT = 0;            // cycle 1
        tests++; if (oFIFO_COUNT !== 3'd0 || oIRQ !== 1'b0) begin fails++; $display("FAIL single_c1 cnt=%0d irq=%b want 0 0", oFIFO_COUNT, oIRQ); end
        tick();                                         // cycle 2
        tests++; if ({oCAUSE_VALID, oCAUSE, oIRQ} !== {1'b1, 3'd5, 1'b1}) begin fails++; $display("FAIL single_c2 v=%b c=%0d irq=%b want 1 5 1", oCAUSE_VALID, oCAUSE, oIRQ); end
        tick(); tick();                                 // cycle 4
        tests++; if (oIRQ !== 1'b1) begin fails++; $display("FAIL single_c4_irq got %b want 1", oIRQ); end
        iIRQ_ACK = 1; tick(); iIRQ_ACK = 0;             // cycle 5
        tests++; if ({oIRQ, oCAUSE_VALID, oCAUSE} !== {1'b0, 1'b1, 3'd5}) begin fails++; $display("FAIL single_c5 irq=%b v=%b c=%0d want 0 1 5", oIRQ, oCAUSE_VALID, oCAUSE); end
        tick(); tick();
        tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL single_norereq got %b want 0", oIRQ); end
        iCAUSE_POP = 1; tick(); iCAUSE_POP = 0;
        tests++; if (oFIFO_COUNT !== 3'd0 || oCAUSE_VALID !== 1'b0) begin fails++; $display("FAIL single_pop cnt=%0d v=%b want 0 0", oFIFO_COUNT, oCAUSE_VALID); end
    endtask

    task automatic test_simultaneous();
        int reqs = 0;
        int expc[3] = '{0, 2, 6};
        iEVENT = 8'b0100_0101; tick(); iEVENT = 0;
        for (int c = 0; c < 60 && reqs < 3; c++) begin
            if (oIRQ) begin
                iIRQ_ACK = 1; tick(); iIRQ_ACK = 0; reqs++;
                tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL simul_hold%0d got %b want 0", reqs, oIRQ); end
                tick();
                tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL simul_idle%0d got %b want 0", reqs, oIRQ); end
            end else tick();
        end
        tests++; if (reqs !== 3) begin fails++; $display("FAIL simul_reqs got %0d want 3", reqs); end
        tick(); tick();
        tests++; if (oIRQ !== 1'b0 || oFIFO_COUNT !== 3'd3) begin fails++; $display("FAIL simul_after irq=%b cnt=%0d want 0 3", oIRQ, oFIFO_COUNT); end
        for (int k = 0; k < 3; k++) begin
            tests++; if (oCAUSE_VALID !== 1'b1 || oCAUSE !== 3'(expc[k])) begin fails++; $display("FAIL simul_pop%0d v=%b c=%0d want 1 %0d", k, oCAUSE_VALID, oCAUSE, expc[k]); end
            iCAUSE_POP = 1; tick(); iCAUSE_POP = 0;
        end
        tests++; if (oFIFO_COUNT !== 3'd0) begin fails++; $display("FAIL simul_empty got %0d want 0", oFIFO_COUNT); end
    endtask

    task automatic test_full_coalesce();
        int got = 0;
        int expc[5] = '{1, 2, 4, 3, 7};
        iIRQ_ENABLE = 0;
        iEVENT = 8'b0001_0111; tick(); iEVENT = 0;
        tick(); tick(); tick(); tick();
        tests++; if (oFIFO_COUNT !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", oFIFO_COUNT); end
        iEVENT = 8'b1000_1000; tick(); iEVENT = 0; tick();
        tests++; if (oFIFO_COUNT !== 3'd4 || oCOALESCE !== 1'b0) begin fails++; $display("FAIL full_parked cnt=%0d coal=%b want 4 0", oFIFO_COUNT, oCOALESCE); end
        iEVENT = 8'h08; tick(); iEVENT = 0;
        tests++; if (oCOALESCE !== 1'b1) begin fails++; $display("FAIL coal_set got %b want 1", oCOALESCE); end
        iCOALESCE_CLR = 1; tick(); iCOALESCE_CLR = 0;
        tests++; if (oCOALESCE !== 1'b0) begin fails++; $display("FAIL coal_clr got %b want 0", oCOALESCE); end
        tests++; if (oCAUSE !== 3'd0) begin fails++; $display("FAIL full_head got %0d want 0", oCAUSE); end
        iCAUSE_POP = 1; tick(); iCAUSE_POP = 0;
        tests++; if (oFIFO_COUNT !== 3'd3) begin fails++; $display("FAIL full_afterpop got %0d want 3", oFIFO_COUNT); end
        tick();
        tests++; if (oFIFO_COUNT !== 3'd4) begin fails++; $display("FAIL full_refill got %0d want 4", oFIFO_COUNT); end
        for (int c = 0; c < 40 && oCAUSE_VALID; c++) begin
            if (got < 5) begin
                tests++; if (oCAUSE !== 3'(expc[got])) begin fails++; $display("FAIL drain%0d got %0d want %0d", got, oCAUSE, expc[got]); end
            end
            got++;
            iCAUSE_POP = 1; tick(); iCAUSE_POP = 0;
        end
        tests++; if (got !== 5 || oFIFO_COUNT !== 3'd0) begin fails++; $display("FAIL drain_total got %0d cnt=%0d want 5 0", got, oFIFO_COUNT); end
        iIRQ_ENABLE = 1; tick(); tick();
        tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL discard_noirq got %b want 0", oIRQ); end
    endtask

    task automatic test_busy_enable();
        iIRQ_BUSY = 1;
        iEVENT = 8'h02; tick(); iEVENT = 0;
        tick(); tick(); tick(); tick();
        tests++; if (oIRQ !== 1'b0 || oFIFO_COUNT !== 3'd1) begin fails++; $display("FAIL busy_hold irq=%b cnt=%0d want 0 1", oIRQ, oFIFO_COUNT); end
        iIRQ_BUSY = 0; tick();
        tests++; if (oIRQ !== 1'b1) begin fails++; $display("FAIL busy_drop got %b want 1", oIRQ); end
        iIRQ_BUSY = 1; tick(); tick();
        tests++; if (oIRQ !== 1'b1) begin fails++; $display("FAIL busy_inreq got %b want 1", oIRQ); end
        iIRQ_ENABLE = 0; tick();
        tests++; if (oIRQ !== 1'b1) begin fails++; $display("FAIL endrop_inreq got %b want 1", oIRQ); end
        iIRQ_ACK = 1; tick(); iIRQ_ACK = 0;
        tests++; if (oIRQ !== 1'b0) begin fails++; $display("FAIL busy_ack got %b want 0", oIRQ); end
        iIRQ_ENABLE = 1; iIRQ_BUSY = 0;
        iCAUSE_POP = 1; tick(); iCAUSE_POP = 0;
        iEVENT_MASK = 8'hFD;
        iEVENT = 8'h02; tick(); iEVENT = 0;
        tick(); tick(); tick();
        tests++; if (oFIFO_COUNT !== 3'd0 || oIRQ !== 1'b0) begin fails++; $display("FAIL masked cnt=%0d irq=%b want 0 0", oFIFO_COUNT, oIRQ); end
        iEVENT_MASK = 8'hFF;
    endtask

    task automatic test_reset_mid_req();
        bit reached = 0;
        iEVENT = 8'h18; tick(); iEVENT = 0;
        for (int c = 0; c < 10 && !reached; c++) begin
            tick();
            if (oIRQ && oFIFO_COUNT == 3'd2) reached = 1;
        end
        tests++; if (!reached) begin fails++; $display("FAIL midreq_setup irq=%b cnt=%0d want 1 2", oIRQ, oFIFO_COUNT); end
        #2 iRESET = 1;
        #1;
        model_reset();
        tests++; if ({oIRQ, oCAUSE_VALID, oFIFO_COUNT} !== 5'd0) begin fails++; $display("FAIL midreq_async irq=%b v=%b cnt=%0d want 0 0 0", oIRQ, oCAUSE_VALID, oFIFO_COUNT); end
        tick(); iRESET = 0;
        tick(); tick(); tick(); tick(); tick();
        tests++; if (oIRQ !== 1'b0 || oFIFO_COUNT !== 3'd0) begin fails++; $display("FAIL midreq_after irq=%b cnt=%0d want 0 0", oIRQ, oFIFO_COUNT); end
    endtask

    task automatic test_random();
        logic [8:0] expVec, obsVec;
        iRESET = 1; tick(); iRESET = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) iEVENT = 8'($urandom);
            if (c % 250 == 0) iEVENT_MASK = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            iIRQ_ENABLE   = ($urandom_range(0, 9) != 0);
            iIRQ_BUSY     = ($urandom_range(0, 3) == 0);
            iIRQ_ACK      = ($urandom_range(0, 2) == 0);
            iCAUSE_POP    = ($urandom_range(0, 2) == 0);
            iCOALESCE_CLR = ($urandom_range(0, 7) == 0);
            tick();
            expVec = {mPhase == 1, mQ.size() != 0, (mQ.size() != 0) ? 3'(mQ[0].cause) : 3'd0, 3'(mQ.size()), mCoal};
            obsVec = {oIRQ, oCAUSE_VALID, oCAUSE_VALID ? oCAUSE : 3'd0, oFIFO_COUNT, oCOALESCE};
            tests++;
            if (obsVec !== expVec) begin
                fails++;
                $display("FAIL random_c%0d {irq,v,cause,cnt,coal} got %b want %b", c, obsVec, expVec);
            end
        end
        iEVENT = 0; iIRQ_ACK = 0; iCAUSE_POP = 0; iCOALESCE_CLR = 0; iIRQ_BUSY = 0; iIRQ_ENABLE = 1;
        iEVENT_MASK = 8'hFF;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full_coalesce();
        test_busy_enable();
        test_reset_mid_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
